// File: rtl/i2c_pkg.sv
// Shared types for the I2C masters: FSM states, bit-phase numbering and R/W bit value.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      ADDR  = 3'd2,
      ACK   = 3'd3,
      DATA  = 3'd4,
      STOP  = 3'd5
   } state_e;

   localparam logic [1:0] P0 = 2'd0;
   localparam logic [1:0] P1 = 2'd1;
   localparam logic [1:0] P2 = 2'd2;
   localparam logic [1:0] P3 = 2'd3;

   localparam logic RW_WRITE = 1'b0;

   // Open-drain: a 0 on the wire means pull low, a 1 means release.
   function automatic logic sda_drive(input logic bit_val);
      return ~bit_val;
   endfunction

endpackage

// File: rtl/i2c_tick_detect.sv
// Turns every level change of the divided i2c_clk into a one-cycle tick in the ref_clk domain.
module i2c_tick_detect (
   input  logic clk_i,
   input  logic rst_i,
   input  logic lvl_i,
   output logic tick_o
);

   logic lvl_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lvl_q <= 1'b0;
      end else begin
         lvl_q <= lvl_i;
      end
   end

   assign tick_o = lvl_i ^ lvl_q;

endmodule

// File: rtl/i2c_master_write.sv
// Write-only I2C master: START, address+W, N data bytes with ACK check, STOP, on open-drain pads.
// Optional SCL clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_master_write
   import i2c_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 7
) (
   input  logic              ref_clk,
   input  logic              rst,
   input  logic              i2c_clk,
   input  logic              start,
   input  logic [ADDR_W-1:0] dev_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic              ack_err,
   output logic              scl_oe,
   output logic              sda_oe,
   input  logic              scl_i,
   input  logic              sda_i
);

   state_e              state_q, state_d;
   logic [1:0]          phase_q, phase_d;
   logic [2:0]          bit_q, bit_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                scl_oe_q, scl_oe_d;
   logic                sda_oe_q, sda_oe_d;
   logic                nack_q, nack_d;
   logic                ack_err_q, ack_err_d;
   logic                done_q, done_d;
   logic                wr_ready_c;
   logic                tick;
   logic                hold;
   logic                adv;

   i2c_tick_detect u_tick (
      .clk_i  (ref_clk),
      .rst_i  (rst),
      .lvl_i  (i2c_clk),
      .tick_o (tick)
   );

   // phase_q names the phase the next tick will enter; P2/P3 pending means SCL is currently released.
`ifdef I2C_CLK_STRETCH_EN
   assign hold = !scl_oe_q && !scl_i && ((phase_q == P2) || (phase_q == P3)) && (state_q != IDLE);
`else
   logic unused_scl;
   assign unused_scl = scl_i;
   assign hold       = 1'b0;
`endif

   assign adv = tick & ~hold;

   always_ff @(posedge ref_clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         phase_q   <= P0;
         bit_q     <= 3'd0;
         shift_q   <= '0;
         scl_oe_q  <= 1'b0;
         sda_oe_q  <= 1'b0;
         nack_q    <= 1'b0;
         ack_err_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         scl_oe_q  <= scl_oe_d;
         sda_oe_q  <= sda_oe_d;
         nack_q    <= nack_d;
         ack_err_q <= ack_err_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      scl_oe_d   = scl_oe_q;
      sda_oe_d   = sda_oe_q;
      nack_d     = nack_q;
      ack_err_d  = ack_err_q;
      done_d     = 1'b0;
      wr_ready_c = 1'b0;

      if (state_q == IDLE) begin
         if (start) begin
            state_d   = START;
            phase_d   = P0;
            bit_d     = 3'd0;
            shift_d   = DATA_W'({dev_addr, RW_WRITE});
            nack_d    = 1'b0;
            ack_err_d = 1'b0;
         end
      end else if (adv) begin
         phase_d = phase_q + 2'd1;
         case (state_q)
            START: begin
               case (phase_q)
                  P1: sda_oe_d = 1'b1;
                  P3: begin
                     scl_oe_d = 1'b1;
                     state_d  = ADDR;
                  end
                  default: ;
               endcase
            end

            ADDR, DATA: begin
               case (phase_q)
                  P0: sda_oe_d = sda_drive(shift_q[DATA_W-1]);
                  P1: scl_oe_d = 1'b0;
                  P3: begin
                     scl_oe_d = 1'b1;
                     shift_d  = shift_q << 1;
                     bit_d    = bit_q + 3'd1;
                     if (bit_q == 3'd7) begin
                        state_d = ACK;
                     end
                  end
                  default: ;
               endcase
            end

            ACK: begin
               case (phase_q)
                  P0: sda_oe_d = 1'b0;
                  P1: scl_oe_d = 1'b0;
                  P2: begin
                     nack_d = sda_i;
                     if (sda_i) begin
                        ack_err_d = 1'b1;
                     end
                  end
                  P3: begin
                     scl_oe_d = 1'b1;
                     if (nack_q || !wr_valid) begin
                        state_d = STOP;
                     end else begin
                        // Handshake and shifter load happen on this same edge.
                        wr_ready_c = 1'b1;
                        shift_d    = wr_data;
                        state_d    = DATA;
                     end
                  end
                  default: ;
               endcase
            end

            STOP: begin
               case (phase_q)
                  P0: sda_oe_d = 1'b1;
                  P1: scl_oe_d = 1'b0;
                  P2: sda_oe_d = 1'b0;
                  P3: begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
                  default: ;
               endcase
            end

            default: state_d = IDLE;
         endcase
      end
   end

   assign wr_ready = wr_ready_c;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign ack_err  = ack_err_q;
   assign scl_oe   = scl_oe_q;
   assign sda_oe   = sda_oe_q;

endmodule
